// File: rtl/alu_pkg.sv
// Shared types and constants for the shifter result stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int SHAMT_W = 2;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_e;

    // One buffered result: {lost, zero, data}, DATA_W+2 bits.
    typedef struct packed {
        logic              lost;
        logic              zero;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/alu_shift_result_stage_if.sv
// Handshake bundle between shifter, result stage and result bus consumer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs.
interface alu_shift_result_stage_if #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [DATA_W-1:0]  in_src;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_zero;
    logic               out_lost;
    logic [CNT_W-1:0]   out_cnt;

    // Result stage side.
    modport slave (
        input  in_valid, in_data, in_src, in_shamt, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_lost, out_cnt
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_src, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_lost, out_cnt
    );
endinterface

// File: rtl/alu_shift_flag_gen.sv
// Status flags for a right-shift result: zero result and shifted-out ones.
// Latency: combinational.
// Backpressure: none.
module alu_shift_flag_gen #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic [DATA_W-1:0]  in_src_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    output logic               zero_o,
    output logic               lost_o
);
    logic [DATA_W-1:0] mask;

    // Low in_shamt bits of the operand are the ones the shifter discarded;
    // the mask stays at DATA_W bits so shamt=0 yields an empty mask.
    always_comb begin
        mask   = (DATA_W'(1) << in_shamt_i) - DATA_W'(1);
        zero_o = (in_data_i == '0);
        lost_o = |(in_src_i & mask);
    end
endmodule

// File: rtl/alu_shift_result_stage.sv
// Two-entry registered output stage behind the right shifter, with flags and a delivery counter.
// Latency: 1 cycle from push to out_*; full throughput when the consumer is always ready.
// Backpressure: main+skid buffer; in_ready (registered) drops only when both entries are held.
module alu_shift_result_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_shift_result_stage_if.slave bus
);
    state_e           state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic             zero;
    logic             lost;

    alu_shift_flag_gen #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_flag_gen (
        .in_data_i  (bus.in_data),
        .in_src_i   (bus.in_src),
        .in_shamt_i (bus.in_shamt),
        .zero_o     (zero),
        .lost_o     (lost)
    );

    // Handshake qualifiers and the entry that would be captured this cycle.
    always_comb begin
        push      = bus.in_valid & in_ready_q;
        pop       = (state_q != S_EMPTY) & bus.out_ready;
        new_entry = '{lost: lost, zero: zero, data: bus.in_data};
    end

    // Occupancy FSM, entry registers, registered in_ready and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        main_q  <= new_entry;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_q <= new_entry;
                    end else if (push) begin
                        skid_q     <= new_entry;
                        state_q    <= S_TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only the pop side can move.
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = main_q.data;
    assign bus.out_zero  = main_q.zero;
    assign bus.out_lost  = main_q.lost;
    assign bus.out_cnt   = cnt_q;
endmodule
